// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
// States stay plain logic constants so legacy code comparing raw bits still works.
package kgprisc_rf_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned CONFLICT_W = 16;

    typedef logic [0:0] state_t;

    localparam state_t S_INIT = 1'b0;
    localparam state_t S_RUN  = 1'b1;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request handshakes plus the registered register-file write bus.
// master = requester side, slave = arbiter side.
interface rf_write_arbiter_if
    import kgprisc_rf_pkg::*;
#(
    parameter int unsigned ADDR_W     = kgprisc_rf_pkg::ADDR_W,
    parameter int unsigned DATA_W     = kgprisc_rf_pkg::DATA_W,
    parameter int unsigned CONFLICT_W = kgprisc_rf_pkg::CONFLICT_W
);

    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_W-1:0]     req0_addr;
    logic [DATA_W-1:0]     req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_W-1:0]     req1_addr;
    logic [DATA_W-1:0]     req1_data;

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  grant_id;
    logic                  init_done;
    logic [CONFLICT_W-1:0] conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data, grant_id, init_done, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data, grant_id, init_done, conflict_cnt
    );

endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to rr_ptr.
// rr_ptr moves to the loser of the last accepted grant.
module rr_arb2
    import kgprisc_rf_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = rr_ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Granting requester N points the tie-break at ~N, i.e. at grant[0].
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = grant[0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: zero-fills every register after reset, then
// shares the write port between ALU (req0) and load (req1) writebacks.
module rf_write_arbiter #(
    parameter int unsigned NUM_REGS       = kgprisc_rf_pkg::NUM_REGS,
    parameter int unsigned ADDR_W         = kgprisc_rf_pkg::ADDR_W,
    parameter int unsigned DATA_W         = kgprisc_rf_pkg::DATA_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    rf_write_arbiter_if.slave   bus
);

    import kgprisc_rf_pkg::*;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_INIT : S_RUN;
    localparam logic   RESET_DONE  = CLEAR_ON_RESET ? 1'b0 : 1'b1;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     clear_ptr_q, clear_ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    logic                  grant_id_q, grant_id_d;
    logic                  init_done_q, init_done_d;
    logic [CONFLICT_W-1:0] conflict_q, conflict_d;

    logic       run;
    logic [1:0] req;
    logic [1:0] grant;
    logic       xfer;

    assign run  = (state_q == S_RUN);
    assign req  = {bus.req1_valid, bus.req0_valid} & {2{run}};
    assign xfer = |grant;

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (xfer),
        .grant   (grant)
    );

    // Gated with reset so readies are low while reset is held, even with CLEAR_ON_RESET=0.
    assign bus.req0_ready = grant[0] & reset;
    assign bus.req1_ready = grant[1] & reset;

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_id_d  = grant_id_q;
        init_done_d = init_done_q;
        conflict_d  = conflict_q;

        case (state_q)
            S_INIT: begin
                wr_en_d     = 1'b1;
                wr_addr_d   = clear_ptr_q;
                wr_data_d   = '0;
                grant_id_d  = 1'b0;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                if (xfer) begin
                    wr_en_d    = 1'b1;
                    grant_id_d = grant[1];
                    wr_addr_d  = grant[1] ? bus.req1_addr : bus.req0_addr;
                    wr_data_d  = grant[1] ? bus.req1_data : bus.req0_data;
                end
                if (bus.req0_valid && bus.req1_valid && (conflict_q != '1)) begin
                    conflict_d = conflict_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            clear_ptr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            grant_id_q  <= 1'b0;
            init_done_q <= RESET_DONE;
            conflict_q  <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            grant_id_q  <= grant_id_d;
            init_done_q <= init_done_d;
            conflict_q  <= conflict_d;
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.init_done    = init_done_q;
    assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a request-level model predicts each
// register-file write; a monitor compares every cycle's write port against it.
module tb_rf_write_arbiter;

    import kgprisc_rf_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .NUM_REGS       (32),
        .ADDR_W         (5),
        .DATA_W         (32),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        id;
        logic        idone;
    } wr_t;

    wr_t expq[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: pending request per requester, tie preference, conflict count.
    logic        p0_v = 1'b0, p1_v = 1'b0;
    logic [4:0]  p0_a = '0, p1_a = '0;
    logic [31:0] p0_d = '0, p1_d = '0;
    int unsigned favor = 0;
    int unsigned conf  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one write expected per queued item, otherwise the port must be idle.
    initial begin
        wr_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("wr_en",     32'(bus.wr_en),     32'd1);
                    check("wr_addr",   32'(bus.wr_addr),   32'(e.addr));
                    check("wr_data",   bus.wr_data,        e.data);
                    check("grant_id",  32'(bus.grant_id),  32'(e.id));
                    check("init_done", 32'(bus.init_done), 32'(e.idone));
                end else begin
                    check("wr_en_idle", 32'(bus.wr_en), 32'd0);
                end
            end
        end
    end

    task automatic drive();
        bus.req0_valid = p0_v;
        bus.req0_addr  = p0_a;
        bus.req0_data  = p0_d;
        bus.req1_valid = p1_v;
        bus.req1_addr  = p1_a;
        bus.req1_data  = p1_d;
    endtask

    task automatic gen_reqs(input int unsigned pct);
        if (!p0_v && ($urandom_range(99) < pct)) begin
            p0_v = 1'b1;
            p0_a = 5'($urandom);
            p0_d = $urandom;
        end
        if (!p1_v && ($urandom_range(99) < pct)) begin
            p1_v = 1'b1;
            p1_a = 5'($urandom);
            p1_d = $urandom;
        end
    endtask

    task automatic model_reset();
        favor = 0;
        conf  = 0;
        expq.delete();
    endtask

    // One init cycle: requests are ignored and register idx is cleared.
    task automatic init_step(input int unsigned idx);
        wr_t e;
        drive();
        #1;
        check("init_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("init_req1_ready", 32'(bus.req1_ready), 32'd0);
        e.addr  = 5'(idx);
        e.data  = '0;
        e.id    = 1'b0;
        e.idone = (idx == 31);
        expq.push_back(e);
        @(negedge clock);
    endtask

    // One run cycle, entered and left at a falling edge.
    task automatic step();
        int  g;
        wr_t e;
        drive();
        #1;
        g = -1;
        if (p0_v && p1_v) begin
            g = int'(favor);
            if (conf < 65535) conf++;
        end else if (p0_v) begin
            g = 0;
        end else if (p1_v) begin
            g = 1;
        end
        check("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
        check("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
        if (g == 0) begin
            e.addr = p0_a; e.data = p0_d; e.id = 1'b0; e.idone = 1'b1;
            expq.push_back(e);
            p0_v  = 1'b0;
            favor = 1;
        end else if (g == 1) begin
            e.addr = p1_a; e.data = p1_d; e.id = 1'b1; e.idone = 1'b1;
            expq.push_back(e);
            p1_v  = 1'b0;
            favor = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        drive();
        repeat (3) @(negedge clock);

        // Reset state, with both valids raised to show readies stay low.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("rst_wr_en",     32'(bus.wr_en),        32'd0);
        check("rst_wr_addr",   32'(bus.wr_addr),      32'd0);
        check("rst_wr_data",   bus.wr_data,           32'd0);
        check("rst_grant_id",  32'(bus.grant_id),     32'd0);
        check("rst_init_done", 32'(bus.init_done),    32'd0);
        check("rst_conflict",  32'(bus.conflict_cnt), 32'd0);
        check("rst_req0_ready", 32'(bus.req0_ready),  32'd0);
        check("rst_req1_ready", 32'(bus.req1_ready),  32'd0);
        @(negedge clock);

        model_reset();
        reset = 1'b1;
        for (int unsigned i = 0; i < 32; i++) init_step(i);
        check("init_done_after", 32'(bus.init_done), 32'd1);

        // req0 alone, then req1 alone to point the tie-break back at req0.
        p0_v = 1'b1; p0_a = 5'd3; p0_d = 32'd16;
        step();
        step();
        p1_v = 1'b1; p1_a = 5'd9; p1_d = 32'hCAFE_0001;
        step();
        step();

        // Tie from rr_ptr=0: req0 then req1.
        p0_v = 1'b1; p0_a = 5'd1; p0_d = 32'd5;
        p1_v = 1'b1; p1_a = 5'd2; p1_d = 32'hFFFF_FFF9;
        step();
        step();
        check("conflict_pair", 32'(bus.conflict_cnt), conf);
        step();

        // Six cycles of continuous contention.
        for (int unsigned i = 0; i < 6; i++) begin
            gen_reqs(100);
            step();
        end
        check("conflict_six", 32'(bus.conflict_cnt), conf);

        for (int unsigned i = 0; i < 400; i++) begin
            gen_reqs(55);
            step();
        end
        check("conflict_rand", 32'(bus.conflict_cnt), conf);

        // Reset after ten init writes: output drops at once, init restarts at 0.
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        gen_reqs(100);
        for (int unsigned i = 0; i < 10; i++) init_step(i);
        reset = 1'b0;
        #1;
        check("midinit_wr_en",     32'(bus.wr_en),     32'd0);
        check("midinit_init_done", 32'(bus.init_done), 32'd0);
        check("midinit_req0_ready", 32'(bus.req0_ready), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int unsigned i = 0; i < 32; i++) init_step(i);
        check("conflict_after_init", 32'(bus.conflict_cnt), 32'd0);

        for (int unsigned i = 0; i < 50; i++) begin
            gen_reqs(70);
            step();
        end

        // Drive the counter into saturation and hold it there.
        for (int unsigned i = 0; i < 65540; i++) begin
            gen_reqs(100);
            step();
        end
        check("conflict_sat", 32'(bus.conflict_cnt), 32'h0000_FFFF);
        for (int unsigned i = 0; i < 3; i++) begin
            gen_reqs(100);
            step();
        end
        check("conflict_hold", 32'(bus.conflict_cnt), conf);

        p0_v = 1'b0;
        p1_v = 1'b0;
        step();
        step();
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: req0 (ALU result) and req1 (load/memory result). After reset it first runs an init sequence that writes zero to every register, then grants write access round-robin via valid/ready handshakes. Registered outputs drive the register file's write-enable, write-address and write-data inputs directly. It also keeps a saturating conflict counter for performance debug.

Parameters:
NUM_REGS, 32, number of architectural registers cleared during init
ADDR_W, 5, register address width
DATA_W, 32, write data width
CLEAR_ON_RESET, 1, 1 = run zero-fill init after reset; 0 = go straight to RUN

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 asserts)
req0_valid  input  1  ALU writeback request
req0_ready  output  1  arbiter accepts req0 this cycle
req0_addr  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU result
req1_valid  input  1  memory writeback request
req1_ready  output  1  arbiter accepts req1 this cycle
req1_addr  input  ADDR_W  load destination register
req1_data  input  DATA_W  load result
wr_en  output  1  register file write enable (registered)
wr_addr  output  ADDR_W  register file write address (registered)
wr_data  output  DATA_W  register file write data (registered)
grant_id  output  1  source of the current wr_en pulse: 0=req0, 1=req1 (registered)
init_done  output  1  high once init completes
conflict_cnt  output  16  saturating count of cycles where both valids were high in RUN

Behaviour:
- Reset (reset=0, async): state=S_INIT (S_RUN if CLEAR_ON_RESET=0); clear_ptr=0; rr_ptr=0; wr_en=0, wr_addr=0, wr_data=0, grant_id=0, init_done=0 (1 if CLEAR_ON_RESET=0), conflict_cnt=0. req0_ready and req1_ready are 0 while reset is asserted.
- S_INIT: both readies held 0. Each edge: wr_en<=1, wr_addr<=clear_ptr, wr_data<=0, grant_id<=0, clear_ptr++. On the edge that issues clear_ptr==NUM_REGS-1: state<=S_RUN, init_done<=1. Result: exactly NUM_REGS consecutive wr_en pulses, addresses 0..NUM_REGS-1.
- S_RUN grant (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester at rr_ptr.
  - None valid: no grant.
  - reqN_ready = (state==S_RUN) & grantN. Ready may depend on valid; requesters must not make valid depend on ready. Requesters hold valid/addr/data stable until accepted.
- Transfer when reqN_valid & reqN_ready. On that edge: wr_en<=1, wr_addr<=reqN_addr, wr_data<=reqN_data, grant_id<=N, rr_ptr<=~N. Latency is 1 cycle from acceptance to wr_en. Throughput is 1 write/cycle.
- No transfer: wr_en<=0; wr_addr, wr_data and grant_id hold their values.
- conflict_cnt increments on every S_RUN edge with both valids high. It saturates at 16'hFFFF and never wraps.
- Both requesters targeting the same address: writes are serialised in grant order, and the later grant's data ends up in the register.
- Writes to address 0 are passed through unmodified. Register-0 semantics are owned by the register file.
- Reset mid-init: the sequence restarts at address 0. Reset mid-RUN: the in-flight wr_en is dropped immediately. Unaccepted requests remain the requesters' responsibility.
- init_done never drops except on reset.

Decomposition:
- Shared package kgprisc_rf_pkg holds: ADDR_W, DATA_W and NUM_REGS constants; the state typedef {S_INIT, S_RUN}; and the CONFLICT_W=16 constant.
- One sub-module, rr_arb2. It contains the 2-way round-robin grant logic plus the rr_ptr register, with inputs clock, reset, req[1:0] and advance, and output grant[1:0]. The top level owns the FSM, init pointer, output registers and counter.

Test Plan:
- Release reset with CLEAR_ON_RESET=1 and no requests -> 32 consecutive wr_en pulses with wr_addr 0..31 and wr_data=0; init_done rises with the last pulse; both readies stay 0 throughout init.
- After init, req0 alone (addr=3, data=16) -> req0_ready=1 the same cycle; next cycle wr_en=1, wr_addr=3, wr_data=16, grant_id=0; wr_en returns to 0 the following cycle.
- req0 (addr=1, data=5) and req1 (addr=2, data=-7) both held valid from rr_ptr=0 -> req0 granted first, req1 on the next cycle; wr_addr sequence 1 then 2; conflict_cnt=1.
- Both requesters valid continuously for 6 cycles with changing data -> grants alternate 0,1,0,1,0,1; wr_en stays high for 6 cycles; conflict_cnt counts each cycle both valids are high.
- Assert reset when clear_ptr=10, then release -> wr_en=0 immediately; init restarts at address 0 and completes 32 pulses.
- Force conflict_cnt to 16'hFFFE and hold both valids for 3 cycles -> counter reads 16'hFFFF and holds there.
